// File: rtl/cam_pattern_gen.sv
// Multi-lane framed camera pattern source (FS/LS/IMG/LE/FE + TR training words) for pipeline self-test.
// Latency: outputs registered one cycle behind FSM state; no backpressure, frames stream without stalls.
// Optional CAM_PATGEN_CHECKSUM_EN builds a rotate-xor checksum of each frame's IMG words into frame_sum.
module cam_pattern_gen #(
    parameter int LANES            = 4,
    parameter int PIX_BITS         = 8,
    parameter int COLS             = 1280,
    parameter int ROWS             = 64,
    parameter int LINE_GAP         = 2,
    parameter int INTERFRAME_WORDS = 142,
    parameter int USE_TRIGGER      = 1,
    parameter int SQ_LOG2          = 4
) (
    input  logic                      c,
    input  logic                      r,
    input  logic                      en,
    input  logic                      trigger,
    input  logic [1:0]                mode,
    input  logic [PIX_BITS-1:0]       level,
    output logic [LANES*PIX_BITS-1:0] data,
    output logic [7:0]                sync,
    output logic                      busy,
    output logic                      frame_done,
    output logic [15:0]               frame_count,
    output logic                      trig_missed,
    output logic [31:0]               frame_sum
);

    localparam int          DW        = LANES * PIX_BITS;
    localparam logic [15:0] WORD_LAST = 16'(COLS / LANES - 1);
    localparam logic [15:0] ROW_LAST  = 16'(ROWS - 1);
    localparam logic [15:0] GAP_LAST  = 16'((LINE_GAP > 0) ? LINE_GAP - 1 : 0);
    localparam logic [15:0] IFG_LAST  = 16'((INTERFRAME_WORDS > 0) ? INTERFRAME_WORDS - 1 : 0);
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [2:0] {
        S_IDLE, S_FS, S_LS, S_IMG, S_LE, S_GAP, S_FE, S_IFG
    } state_t;

    state_t              state;
    logic [15:0]         word_idx;
    logic [15:0]         row_idx;
    logic [15:0]         gap_cnt;
    logic [1:0]          mode_q;
    logic [PIX_BITS-1:0] level_q;
    logic [15:0]         lfsr;
    logic                trig_s1, trig_s2, trig_s3, trig_rise;
    logic                start;
    logic                row_done;
    logic [7:0]          sync_code;
    logic [DW-1:0]       pix_word;
    logic [31:0]         px_x, px_y;
    logic [PIX_BITS-1:0] pix;

    always_comb begin
        start    = en & ((USE_TRIGGER != 0) ? trig_rise : 1'b1);
        row_done = ((state == S_LE) && (LINE_GAP == 0)) ||
                   ((state == S_GAP) && (gap_cnt == GAP_LAST));
    end

    always_comb begin
        case (state)
            S_FS:    sync_code = 8'hAA;
            S_LS:    sync_code = 8'h2A;
            S_IMG:   sync_code = 8'h0D;
            S_LE:    sync_code = 8'h12;
            S_FE:    sync_code = 8'h3A;
            default: sync_code = 8'hE9;
        endcase
    end

    // Pixel x spans the full row; the checkerboard parity is bit SQ_LOG2 of x and y.
    always_comb begin
        pix_word = '0;
        px_x     = '0;
        px_y     = 32'(row_idx);
        pix      = '0;
        for (int k = 0; k < LANES; k++) begin
            px_x = 32'(word_idx) * 32'(LANES) + 32'(k);
            case (mode_q)
                2'd0:    pix = PIX_BITS'(px_x + px_y + 32'(frame_count[7:0]));
                2'd1:    pix = (px_x[SQ_LOG2] ^ px_y[SQ_LOG2]) ? ~level_q : level_q;
                2'd2:    pix = level_q;
                default: pix = PIX_BITS'(32'(lfsr) ^ 32'(k));
            endcase
            pix_word[k*PIX_BITS +: PIX_BITS] = pix;
        end
    end

    always_ff @(posedge c) begin
        if (r) begin
            state       <= S_IDLE;
            word_idx    <= '0;
            row_idx     <= '0;
            gap_cnt     <= '0;
            mode_q      <= '0;
            level_q     <= '0;
            lfsr        <= LFSR_SEED;
            trig_s1     <= 1'b0;
            trig_s2     <= 1'b0;
            trig_s3     <= 1'b0;
            trig_rise   <= 1'b0;
            data        <= '0;
            sync        <= 8'hE9;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= '0;
            trig_missed <= 1'b0;
        end else begin
            trig_s1   <= trigger;
            trig_s2   <= trig_s1;
            trig_s3   <= trig_s2;
            trig_rise <= trig_s2 & ~trig_s3;
            if ((USE_TRIGGER != 0) && trig_rise && (state != S_IDLE))
                trig_missed <= 1'b1;

            sync       <= sync_code;
            data       <= (state == S_IMG) ? pix_word : '0;
            busy       <= (state != S_IDLE);
            frame_done <= (state == S_FE);
            if (state == S_FE)
                frame_count <= frame_count + 16'd1;

            case (state)
                S_IDLE: if (start) state <= S_FS;
                S_FS: begin
                    mode_q  <= mode;
                    level_q <= level;
                    lfsr    <= LFSR_SEED;
                    row_idx <= '0;
                    state   <= S_LS;
                end
                S_LS: begin
                    word_idx <= '0;
                    state    <= S_IMG;
                end
                S_IMG: begin
                    lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
                    if (word_idx == WORD_LAST)
                        state <= S_LE;
                    else
                        word_idx <= word_idx + 16'd1;
                end
                S_LE, S_GAP: begin
                    if (row_done) begin
                        if (row_idx == ROW_LAST) begin
                            state <= S_FE;
                        end else begin
                            row_idx <= row_idx + 16'd1;
                            state   <= S_LS;
                        end
                    end else if (state == S_LE) begin
                        gap_cnt <= '0;
                        state   <= S_GAP;
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end
                S_FE: begin
                    gap_cnt <= '0;
                    state   <= (INTERFRAME_WORDS == 0) ? S_IDLE : S_IFG;
                end
                S_IFG: begin
                    if (gap_cnt == IFG_LAST)
                        state <= S_IDLE;
                    else
                        gap_cnt <= gap_cnt + 16'd1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef CAM_PATGEN_CHECKSUM_EN
    logic [31:0] sum_run;
    logic [31:0] pix32;

    always_comb begin
        pix32 = '0;
        for (int i = 0; i < 32 && i < DW; i++)
            pix32[i] = pix_word[i];
    end

    always_ff @(posedge c) begin
        if (r) begin
            sum_run   <= '0;
            frame_sum <= '0;
        end else begin
            if (state == S_FS)
                sum_run <= '0;
            else if (state == S_IMG)
                sum_run <= {sum_run[30:0], sum_run[31]} ^ pix32;
            if (state == S_FE)
                frame_sum <= sum_run;
        end
    end
`else
    assign frame_sum = '0;
`endif

endmodule

// File: tb/tb_cam_pattern_gen.sv
// Bench for cam_pattern_gen: three instances (triggered, tall checkerboard, free-run) checked against
// a frame-level reference model built from the sync/pixel/LFSR/checksum rules.
module tb_cam_pattern_gen;

    logic c = 1'b0;
    always #5 c = ~c;

    logic        r_a, en_a, trig_a, busy_a, done_a, miss_a;
    logic [1:0]  mode_a;
    logic [7:0]  level_a, sync_a;
    logic [31:0] data_a, fsum_a;
    logic [15:0] fc_a;
    logic        r_b, en_b, trig_b, busy_b, done_b, miss_b;
    logic [1:0]  mode_b;
    logic [7:0]  level_b, sync_b;
    logic [31:0] data_b, fsum_b;
    logic [15:0] fc_b;
    logic        r_c, en_c, trig_c, busy_c, done_c, miss_c;
    logic [1:0]  mode_c;
    logic [7:0]  level_c, sync_c;
    logic [31:0] data_c, fsum_c;
    logic [15:0] fc_c;

    cam_pattern_gen #(.LANES(4), .PIX_BITS(8), .COLS(16), .ROWS(4), .LINE_GAP(2),
        .INTERFRAME_WORDS(8), .USE_TRIGGER(1), .SQ_LOG2(3)) dut_a (
        .c(c), .r(r_a), .en(en_a), .trigger(trig_a), .mode(mode_a), .level(level_a),
        .data(data_a), .sync(sync_a), .busy(busy_a), .frame_done(done_a),
        .frame_count(fc_a), .trig_missed(miss_a), .frame_sum(fsum_a));

    cam_pattern_gen #(.LANES(4), .PIX_BITS(8), .COLS(16), .ROWS(32), .LINE_GAP(2),
        .INTERFRAME_WORDS(8), .USE_TRIGGER(1), .SQ_LOG2(3)) dut_b (
        .c(c), .r(r_b), .en(en_b), .trigger(trig_b), .mode(mode_b), .level(level_b),
        .data(data_b), .sync(sync_b), .busy(busy_b), .frame_done(done_b),
        .frame_count(fc_b), .trig_missed(miss_b), .frame_sum(fsum_b));

    cam_pattern_gen #(.LANES(4), .PIX_BITS(8), .COLS(16), .ROWS(4), .LINE_GAP(2),
        .INTERFRAME_WORDS(0), .USE_TRIGGER(0), .SQ_LOG2(3)) dut_c (
        .c(c), .r(r_c), .en(en_c), .trigger(trig_c), .mode(mode_c), .level(level_c),
        .data(data_c), .sync(sync_c), .busy(busy_c), .frame_done(done_c),
        .frame_count(fc_c), .trig_missed(miss_c), .frame_sum(fsum_c));

    int          compared = 0;
    int          mismatched = 0;
    int          sel = 0;
    logic [7:0]  m_sync;
    logic [31:0] m_data, m_fsum;
    logic        m_busy, m_done, m_miss;
    logic [15:0] m_fc;

    always_comb begin
        m_sync = sync_a; m_data = data_a; m_busy = busy_a; m_done = done_a;
        m_fc = fc_a; m_miss = miss_a; m_fsum = fsum_a;
        case (sel)
            1: begin
                m_sync = sync_b; m_data = data_b; m_busy = busy_b; m_done = done_b;
                m_fc = fc_b; m_miss = miss_b; m_fsum = fsum_b;
            end
            2: begin
                m_sync = sync_c; m_data = data_c; m_busy = busy_c; m_done = done_c;
                m_fc = fc_c; m_miss = miss_c; m_fsum = fsum_c;
            end
            default: ;
        endcase
    end

    logic [7:0]  q_sync[$];
    logic [31:0] q_data[$];
    logic [31:0] exp_sum;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    function automatic logic [31:0] model_word(input int md, input int lv, input int fc,
                                               input int w, input int y, input logic [15:0] lf);
        logic [31:0] wd;
        int x, p;
        wd = '0;
        for (int k = 0; k < 4; k++) begin
            x = w * 4 + k;
            case (md)
                0:       p = x + y + (fc & 255);
                1:       p = ((((x >> 3) ^ (y >> 3)) & 1) == 0) ? lv : ~lv;
                2:       p = lv;
                default: p = int'(lf) ^ k;
            endcase
            wd[k*8 +: 8] = 8'(p);
        end
        return wd;
    endfunction

    // Whole expected frame: FS, rows of LS/IMG x4/LE/TR x2, FE.
    task automatic model_frame(input int md, input int lv, input int fc, input int rows);
        logic [15:0] lf;
        logic [31:0] wd;
        q_sync.delete(); q_data.delete();
        exp_sum = '0;
        lf = 16'hACE1;
        q_sync.push_back(8'hAA); q_data.push_back(32'h0);
        for (int y = 0; y < rows; y++) begin
            q_sync.push_back(8'h2A); q_data.push_back(32'h0);
            for (int w = 0; w < 4; w++) begin
                wd = model_word(md, lv, fc, w, y, lf);
                q_sync.push_back(8'h0D); q_data.push_back(wd);
                exp_sum = {exp_sum[30:0], exp_sum[31]} ^ wd;
                lf = lfsr_step(lf);
            end
            q_sync.push_back(8'h12); q_data.push_back(32'h0);
            q_sync.push_back(8'hE9); q_data.push_back(32'h0);
            q_sync.push_back(8'hE9); q_data.push_back(32'h0);
        end
        q_sync.push_back(8'h3A); q_data.push_back(32'h0);
    endtask

    task automatic wait_fs(input int limit, output int n, output bit found);
        found = 0; n = 0;
        while (!found && n < limit) begin
            @(negedge c); n++;
            if (m_sync === 8'hAA) found = 1;
        end
    endtask

    task automatic start_frame_a(output bit found);
        bit f1, f2;
        int n;
        f1 = 0; n = 0;
        while (!f1 && n < 80) begin
            @(negedge c); n++;
            if (busy_a === 1'b0) f1 = 1;
        end
        repeat (2) @(negedge c);
        trig_a = 1'b1;
        wait_fs(12, n, f2);
        trig_a = 1'b0;
        found = f1 & f2;
    endtask

    task automatic test_reset();
        {r_a, r_b, r_c} = 3'b111;
        {en_a, en_b, en_c} = 3'b000;
        {trig_a, trig_b, trig_c} = 3'b000;
        mode_a = 0; mode_b = 0; mode_c = 0;
        level_a = 0; level_b = 0; level_c = 0;
        repeat (3) begin @(negedge c); trig_a = ~trig_a; end
        for (int s = 0; s < 3; s++) begin
            sel = s; #1;
            compared++;
            if ({m_sync, m_data, m_busy, m_done, m_fc, m_miss, m_fsum} !==
                {8'hE9, 32'h0, 1'b0, 1'b0, 16'h0, 1'b0, 32'h0}) begin
                mismatched++;
                $display("FAIL reset inst%0d: sync=%h data=%h busy=%b done=%b fc=%0d miss=%b sum=%h, want E9/0/0/0/0/0/0",
                         s, m_sync, m_data, m_busy, m_done, m_fc, m_miss, m_fsum);
            end
        end
        sel = 0;
        @(negedge c);
        {r_a, r_b, r_c} = 3'b000;
        for (int i = 0; i < 20; i++) begin
            @(negedge c);
            if (i % 2 == 0) trig_a = ~trig_a;
            compared++;
            if (m_sync !== 8'hE9 || m_data !== 32'h0 || m_busy !== 1'b0 || m_fc !== 16'h0) begin
                mismatched++;
                $display("FAIL idle_en0 cycle %0d: sync=%h data=%h busy=%b fc=%0d, want E9/0/0/0",
                         i, m_sync, m_data, m_busy, m_fc);
            end
        end
        trig_a = 1'b0;
        repeat (6) @(negedge c);
        compared++;
        if (m_miss !== 1'b0) begin
            mismatched++;
            $display("FAIL idle_no_miss: trig_missed=%b, want 0", m_miss);
        end
    endtask

    task automatic test_trigger_frame();
        int n, lv;
        bit found;
        sel = 0; en_a = 1'b1; mode_a = 2'd0;
        lv = $urandom_range(0, 255); level_a = 8'(lv);
        repeat (4) @(negedge c);
        trig_a = 1'b1;
        wait_fs(12, n, found);
        trig_a = 1'b0;
        compared++;
        if (!found || n - 1 != 4) begin
            mismatched++;
            $display("FAIL trig_latency: FS found=%0d after %0d cycles, want 4", found, n - 1);
        end
        model_frame(0, lv, 0, 4);
        for (int i = 0; i < q_sync.size(); i++) begin
            if (i > 0) @(negedge c);
            compared++;
            if (m_sync !== q_sync[i] || m_data !== q_data[i] || m_busy !== 1'b1 ||
                m_done !== (i == q_sync.size() - 1)) begin
                mismatched++;
                $display("FAIL trig_frame word %0d: sync=%h data=%h busy=%b done=%b, want sync=%h data=%h busy=1 done=%0d",
                         i, m_sync, m_data, m_busy, m_done, q_sync[i], q_data[i], i == q_sync.size() - 1);
            end
            if (i == 2 || i == 29) begin
                compared++;
                if (m_data !== ((i == 2) ? 32'h03020100 : 32'h1211100F)) begin
                    mismatched++;
                    $display("FAIL grad_corner word %0d: data=%h", i, m_data);
                end
            end
        end
        compared++;
        if (m_fc !== 16'd1 || m_miss !== 1'b0) begin
            mismatched++;
            $display("FAIL trig_frame_end: fc=%0d miss=%b, want 1/0", m_fc, m_miss);
        end
    endtask

    // Called on the FE negedge; times a trigger so its edge lands on the first IDLE cycle.
    task automatic test_idle_edge();
        repeat (5) @(negedge c);
        trig_a = 1'b1;
        for (int j = 6; j <= 9; j++) begin
            @(negedge c);
            compared++;
            if (m_sync !== 8'hE9 || m_busy !== (j < 9)) begin
                mismatched++;
                $display("FAIL idle_edge_gap step %0d: sync=%h busy=%b, want E9 busy=%0d", j, m_sync, m_busy, j < 9);
            end
        end
        @(negedge c);
        trig_a = 1'b0;
        compared++;
        if (m_sync !== 8'hAA) begin
            mismatched++;
            $display("FAIL idle_edge_start: sync=%h, want AA", m_sync);
        end
        model_frame(0, int'(level_a), 1, 4);
        for (int i = 0; i < q_sync.size(); i++) begin
            if (i > 0) @(negedge c);
            compared++;
            if (m_sync !== q_sync[i] || m_data !== q_data[i]) begin
                mismatched++;
                $display("FAIL idle_edge_frame word %0d: sync=%h data=%h, want %h %h",
                         i, m_sync, m_data, q_sync[i], q_data[i]);
            end
            if (i == 2) begin
                compared++;
                if (m_data !== 32'h04030201) begin
                    mismatched++;
                    $display("FAIL grad_offset: data=%h, want 04030201", m_data);
                end
            end
        end
        compared++;
        if (m_fc !== 16'd2 || m_miss !== 1'b0) begin
            mismatched++;
            $display("FAIL idle_edge_end: fc=%0d miss=%b, want 2/0", m_fc, m_miss);
        end
    endtask

    task automatic test_missed();
        int lv, fs_seen;
        bit found;
        sel = 0; mode_a = 2'd3;
        lv = $urandom_range(0, 255); level_a = 8'(lv);
        start_frame_a(found);
        compared++;
        if (!found) begin mismatched++; $display("FAIL missed_start: no FS"); end
        model_frame(3, lv, 2, 4);
        for (int i = 0; i < q_sync.size(); i++) begin
            if (i > 0) @(negedge c);
            if (i == 10) begin mode_a = 2'd1; level_a = ~level_a; end
            if (i == 18) trig_a = 1'b1;
            if (i == 21) trig_a = 1'b0;
            compared++;
            if (m_sync !== q_sync[i] || m_data !== q_data[i]) begin
                mismatched++;
                $display("FAIL lfsr_frame word %0d: sync=%h data=%h, want %h %h",
                         i, m_sync, m_data, q_sync[i], q_data[i]);
            end
        end
        compared++;
        if (m_fc !== 16'd3 || m_miss !== 1'b1) begin
            mismatched++;
            $display("FAIL missed_end: fc=%0d miss=%b, want 3/1", m_fc, m_miss);
        end
        fs_seen = 0;
        repeat (40) begin @(negedge c); if (m_sync === 8'hAA) fs_seen++; end
        compared++;
        if (fs_seen != 0 || m_fc !== 16'd3) begin
            mismatched++;
            $display("FAIL missed_one_frame: extra FS=%0d fc=%0d, want 0/3", fs_seen, m_fc);
        end
    endtask

    task automatic test_checksum();
        logic [31:0] want;
        bit found;
        sel = 0;
        for (int f = 0; f < 3; f++) begin
            mode_a = (f == 0) ? 2'd2 : 2'd3;
            level_a = (f == 0) ? 8'h00 : 8'(32'($urandom_range(0, 255)));
            start_frame_a(found);
            model_frame(int'(mode_a), int'(level_a), 0, 4);
`ifdef CAM_PATGEN_CHECKSUM_EN
            want = exp_sum;
`else
            want = 32'h0;
`endif
            repeat (33) @(negedge c);
            compared++;
            if (!found || m_sync !== 8'h3A || m_fsum !== want) begin
                mismatched++;
                $display("FAIL checksum frame %0d: found=%0d sync=%h sum=%h, want 3A %h", f, found, m_sync, m_fsum, want);
            end
        end
    endtask

    task automatic test_checker();
        int n;
        bit found;
        sel = 1; en_b = 1'b1; mode_b = 2'd1; level_b = 8'h40;
        repeat (4) @(negedge c);
        trig_b = 1'b1;
        wait_fs(12, n, found);
        trig_b = 1'b0;
        compared++;
        if (!found) begin mismatched++; $display("FAIL checker_start: no FS after %0d cycles", n); end
        model_frame(1, 8'h40, 0, 32);
        for (int i = 0; i < q_sync.size(); i++) begin
            if (i > 0) @(negedge c);
            compared++;
            if (m_sync !== q_sync[i] || m_data !== q_data[i]) begin
                mismatched++;
                $display("FAIL checker word %0d: sync=%h data=%h, want %h %h",
                         i, m_sync, m_data, q_sync[i], q_data[i]);
            end
            if (i == 2 || i == 4 || i == 66 || i == 130) begin
                compared++;
                if (m_data !== ((i == 2 || i == 130) ? 32'h40404040 : 32'hBFBFBFBF)) begin
                    mismatched++;
                    $display("FAIL checker_square word %0d: data=%h", i, m_data);
                end
            end
        end
    endtask

    task automatic test_free_run();
        int n, img, fs_seen;
        bit found;
        sel = 2; mode_c = 2'd0; level_c = 8'h00; en_c = 1'b1;
        wait_fs(10, n, found);
        img = 0;
        while (img < 6 && n < 60) begin
            @(negedge c); n++;
            if (m_sync === 8'h0D) img++;
        end
        r_c = 1'b1;
        @(negedge c);
        r_c = 1'b0;
        compared++;
        if (img != 6 || {m_sync, m_data, m_busy, m_done, m_fc} !== {8'hE9, 32'h0, 1'b0, 1'b0, 16'h0}) begin
            mismatched++;
            $display("FAIL midframe_reset: img=%0d sync=%h data=%h busy=%b done=%b fc=%0d, want 6 E9/0/0/0/0",
                     img, m_sync, m_data, m_busy, m_done, m_fc);
        end
        wait_fs(10, n, found);
        compared++;
        if (!found) begin mismatched++; $display("FAIL freerun_start: no FS"); end
        for (int f = 0; f < 3; f++) begin
            model_frame(0, 0, f, 4);
            for (int i = 0; i < q_sync.size(); i++) begin
                if (i > 0) @(negedge c);
                if (f == 2 && i == 10) en_c = 1'b0;
                compared++;
                if (m_sync !== q_sync[i] || m_data !== q_data[i] || m_done !== (i == q_sync.size() - 1)) begin
                    mismatched++;
                    $display("FAIL freerun frame %0d word %0d: sync=%h data=%h done=%b, want %h %h",
                             f, i, m_sync, m_data, m_done, q_sync[i], q_data[i]);
                end
            end
            compared++;
            if (m_fc !== 16'(f + 1)) begin
                mismatched++;
                $display("FAIL freerun_count frame %0d: fc=%0d, want %0d", f, m_fc, f + 1);
            end
            if (f < 2) begin
                @(negedge c);
                compared++;
                if (m_sync !== 8'hE9 || m_busy !== 1'b0 || m_data !== 32'h0) begin
                    mismatched++;
                    $display("FAIL freerun_idle frame %0d: sync=%h busy=%b data=%h, want E9/0/0", f, m_sync, m_busy, m_data);
                end
                @(negedge c);
                compared++;
                if (m_sync !== 8'hAA) begin
                    mismatched++;
                    $display("FAIL freerun_period frame %0d: sync=%h 35 cycles after FS, want AA", f, m_sync);
                end
            end
        end
        fs_seen = 0;
        repeat (30) begin @(negedge c); if (m_sync === 8'hAA) fs_seen++; end
        compared++;
        if (fs_seen != 0 || m_busy !== 1'b0 || m_fc !== 16'd3) begin
            mismatched++;
            $display("FAIL en_drop: extra FS=%0d busy=%b fc=%0d, want 0/0/3", fs_seen, m_busy, m_fc);
        end
    endtask

    initial begin
        test_reset();
        test_trigger_frame();
        test_idle_edge();
        test_missed();
        test_checksum();
        test_checker();
        test_free_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
